// File: rtl/rv_wb_arb_if.sv
// Bus bundle for the write-back arbiter.
// Carries the s0/s1 write request channels, the long-latency issue
// notification, the decode-stage hazard query, and the RF write port.
//   slave  : the arbiter side (rv_wb_arb)
//   master : the surrounding pipeline / RF side
interface rv_wb_arb_if;
  // s0: in-order ALU result
  logic        s0_valid_i;
  logic [4:0]  s0_reg_i;
  logic [63:0] s0_data_i;
  logic        s0_ready_o;
  // s1: long-latency unit result
  logic        s1_valid_i;
  logic [4:0]  s1_reg_i;
  logic [63:0] s1_data_i;
  logic        s1_ready_o;
  // long-latency issue notification
  logic        s1_issue_i;
  logic [4:0]  s1_issue_reg_i;
  // decode-stage hazard query
  logic [4:0]  chk_rs1_i;
  logic [4:0]  chk_rs2_i;
  logic [4:0]  chk_rd_i;
  logic        stall_o;
  logic [31:0] pend_mask_o;
  // RF write port
  logic        wr_en_o;
  logic [4:0]  wr_reg_o;
  logic [63:0] wr_data_o;

  modport slave (
    input  s0_valid_i, s0_reg_i, s0_data_i,
    output s0_ready_o,
    input  s1_valid_i, s1_reg_i, s1_data_i,
    output s1_ready_o,
    input  s1_issue_i, s1_issue_reg_i,
    input  chk_rs1_i, chk_rs2_i, chk_rd_i,
    output stall_o, pend_mask_o,
    output wr_en_o, wr_reg_o, wr_data_o
  );

  modport master (
    output s0_valid_i, s0_reg_i, s0_data_i,
    input  s0_ready_o,
    output s1_valid_i, s1_reg_i, s1_data_i,
    input  s1_ready_o,
    output s1_issue_i, s1_issue_reg_i,
    output chk_rs1_i, chk_rs2_i, chk_rd_i,
    input  stall_o, pend_mask_o,
    input  wr_en_o, wr_reg_o, wr_data_o
  );
endinterface

// File: rtl/rv_wb_arb.sv
// Write-back arbiter and scoreboard for the 64-bit x 32 integer RF.
// Shares the single RF write port between s0 (ALU, preferred) and s1
// (long-latency unit), with a starvation counter that forces s1 to win
// after STARVE_MAX consecutive losses. Tracks registers with an
// outstanding s1 result and flags RAW/WAW hazards for decode.
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : rv_wb_arb_if.slave (request channels, issue, hazard query,
//          RF write port)
module rv_wb_arb #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic         clk,
  input  logic         rstn,
  rv_wb_arb_if.slave   bus
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             force1;
  logic             s0_gnt, s1_gnt;

  logic             wr_en_q;
  logic [4:0]       wr_reg_q;
  logic [63:0]      wr_data_q;
  logic             src_q;

  logic [31:0]      pend_q, pend_d;

  // Arbitration: s0 wins unless s1 has lost STARVE_MAX times in a row.
  always_comb begin
    force1 = bus.s1_valid_i && (cnt_q == STARVE_LIM);
    s0_gnt = bus.s0_valid_i && !force1;
    s1_gnt = bus.s1_valid_i && !s0_gnt;
  end

  // Counter only grows while s1 is waiting and losing; since s0 cannot be
  // granted once the limit is reached, the saturation guard is defensive.
  always_comb begin
    cnt_d = '0;
    if (bus.s1_valid_i && s0_gnt) begin
      cnt_d = (cnt_q == STARVE_LIM) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Scoreboard next state. Clear is applied before set so that a new
  // issue to the register being committed keeps its bit.
  always_comb begin
    pend_d = pend_q;
    if (wr_en_q && src_q) begin
      pend_d[wr_reg_q] = 1'b0;
    end
    if (bus.s1_issue_i && (bus.s1_issue_reg_i != 5'd0)) begin
      pend_d[bus.s1_issue_reg_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      src_q     <= 1'b0;
      pend_q    <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      if (s0_gnt) begin
        wr_en_q   <= (bus.s0_reg_i != 5'd0);
        wr_reg_q  <= bus.s0_reg_i;
        wr_data_q <= bus.s0_data_i;
        src_q     <= 1'b0;
      end else if (s1_gnt) begin
        wr_en_q   <= (bus.s1_reg_i != 5'd0);
        wr_reg_q  <= bus.s1_reg_i;
        wr_data_q <= bus.s1_data_i;
        src_q     <= 1'b1;
      end else begin
        wr_en_q   <= 1'b0;
      end
    end
  end

  assign bus.s0_ready_o  = s0_gnt;
  assign bus.s1_ready_o  = s1_gnt;
  assign bus.wr_en_o     = wr_en_q;
  assign bus.wr_reg_o    = wr_reg_q;
  assign bus.wr_data_o   = wr_data_q;
  assign bus.pend_mask_o = pend_q;
  assign bus.stall_o     = pend_q[bus.chk_rs1_i] | pend_q[bus.chk_rs2_i] |
                           pend_q[bus.chk_rd_i];

endmodule

// File: tb/tb_rv_wb_arb.sv
// Directed bench for rv_wb_arb: one table row per clock cycle, each row
// giving the cycle's inputs plus the outputs expected during that cycle
// (combinational outputs from this row's inputs, registered outputs from
// the preceding edges). A hand-written sequence covers async reset.
module tb_rv_wb_arb;

  logic clk;
  logic rstn;

  rv_wb_arb_if bus ();

  rv_wb_arb #(.STARVE_MAX(4), .CNT_W(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s0v;
    logic [4:0]  s0r;
    logic [63:0] s0d;
    logic        s1v;
    logic [4:0]  s1r;
    logic [63:0] s1d;
    logic        iss;
    logic [4:0]  issr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        e_s0rdy;
    logic        e_s1rdy;
    logic        e_stall;
    logic        e_wen;
    logic [4:0]  e_wreg;
    logic [63:0] e_wd;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(input logic s0v, input logic [4:0] s0r, input logic [63:0] s0d,
                     input logic s1v, input logic [4:0] s1r, input logic [63:0] s1d,
                     input logic iss, input logic [4:0] issr,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic e_s0rdy, input logic e_s1rdy, input logic e_stall,
                     input logic e_wen, input logic [4:0] e_wreg, input logic [63:0] e_wd,
                     input logic [31:0] e_pend);
    vec_t v;
    v.s0v = s0v; v.s0r = s0r; v.s0d = s0d;
    v.s1v = s1v; v.s1r = s1r; v.s1d = s1d;
    v.iss = iss; v.issr = issr;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.e_s0rdy = e_s0rdy; v.e_s1rdy = e_s1rdy; v.e_stall = e_stall;
    v.e_wen = e_wen; v.e_wreg = e_wreg; v.e_wd = e_wd; v.e_pend = e_pend;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.s0_valid_i     = v.s0v;
    bus.s0_reg_i       = v.s0r;
    bus.s0_data_i      = v.s0d;
    bus.s1_valid_i     = v.s1v;
    bus.s1_reg_i       = v.s1r;
    bus.s1_data_i      = v.s1d;
    bus.s1_issue_i     = v.iss;
    bus.s1_issue_reg_i = v.issr;
    bus.chk_rs1_i      = v.rs1;
    bus.chk_rs2_i      = v.rs2;
    bus.chk_rd_i       = v.rd;
  endtask

  task automatic idle_inputs();
    vec_t v;
    v = '{default: '0};
    drive(v);
  endtask

  initial begin
    // s0 x1 / s1 x2 payloads for the contention window
    localparam logic [63:0] D1 = 64'h11;
    localparam logic [63:0] D2 = 64'h22;
    localparam logic [63:0] DB = 64'hDEAD_BEEF;

    //   s0v s0r s0d    s1v s1r s1d   iss issr rs1 rs2 rd | s0rdy s1rdy stall wen wreg wd  pend
    add(0, 0, 0,      0, 0, 0,      0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0,  32'h0);       // 0 idle
    add(0, 0, 0,      0, 0, 0,      1, 5,  5,  0, 0,   0, 0, 0, 0, 0, 0,  32'h0);       // 1 issue x5
    add(0, 0, 0,      0, 0, 0,      0, 0,  5,  0, 0,   0, 0, 1, 0, 0, 0,  32'h20);      // 2
    add(0, 0, 0,      0, 0, 0,      0, 0,  5,  0, 0,   0, 0, 1, 0, 0, 0,  32'h20);      // 3
    add(0, 0, 0,      1, 5, DB,     0, 0,  5,  0, 0,   0, 1, 1, 0, 0, 0,  32'h20);      // 4 s1 writes x5
    add(0, 0, 0,      0, 0, 0,      0, 0,  5,  0, 0,   0, 0, 1, 1, 5, DB, 32'h20);      // 5 commit edge next
    add(0, 0, 0,      0, 0, 0,      0, 0,  5,  0, 0,   0, 0, 0, 0, 5, 0,  32'h0);       // 6 x5 released
    // contention: s0 wins 4, s1 wins the 5th, repeat
    add(1, 1, D1,     1, 2, D2,     0, 0,  0,  0, 0,   1, 0, 0, 0, 5, 0,  32'h0);       // 7
    add(1, 1, D1,     1, 2, D2,     0, 0,  0,  0, 0,   1, 0, 0, 1, 1, D1, 32'h0);       // 8
    add(1, 1, D1,     1, 2, D2,     0, 0,  0,  0, 0,   1, 0, 0, 1, 1, D1, 32'h0);       // 9
    add(1, 1, D1,     1, 2, D2,     0, 0,  0,  0, 0,   1, 0, 0, 1, 1, D1, 32'h0);       // 10
    add(1, 1, D1,     1, 2, D2,     0, 0,  0,  0, 0,   0, 1, 0, 1, 1, D1, 32'h0);       // 11 forced s1
    add(1, 1, D1,     1, 2, D2,     0, 0,  0,  0, 0,   1, 0, 0, 1, 2, D2, 32'h0);       // 12
    add(1, 1, D1,     1, 2, D2,     0, 0,  0,  0, 0,   1, 0, 0, 1, 1, D1, 32'h0);       // 13
    add(1, 1, D1,     1, 2, D2,     0, 0,  0,  0, 0,   1, 0, 0, 1, 1, D1, 32'h0);       // 14
    add(1, 1, D1,     1, 2, D2,     0, 0,  0,  0, 0,   1, 0, 0, 1, 1, D1, 32'h0);       // 15
    add(1, 1, D1,     1, 2, D2,     0, 0,  0,  0, 0,   0, 1, 0, 1, 1, D1, 32'h0);       // 16 forced s1
    add(0, 0, 0,      0, 0, 0,      0, 0,  0,  0, 0,   0, 0, 0, 1, 2, D2, 32'h0);       // 17
    // x0: consumed, no write, no pending bit
    add(1, 0, 64'h1234, 0, 0, 0,    1, 0,  0,  0, 0,   1, 0, 0, 0, 2, 0,  32'h0);       // 18
    add(0, 0, 0,      0, 0, 0,      0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0,  32'h0);       // 19
    // same-edge set/clear on x7
    add(0, 0, 0,      0, 0, 0,      1, 7,  0,  0, 0,   0, 0, 0, 0, 0, 0,  32'h0);       // 20 issue x7
    add(0, 0, 0,      1, 7, 64'h77, 0, 0,  0,  0, 7,   0, 1, 1, 0, 0, 0,  32'h80);      // 21 s1 writes x7
    add(0, 0, 0,      0, 0, 0,      1, 7,  0,  0, 7,   0, 0, 1, 1, 7, 64'h77, 32'h80);  // 22 commit + reissue
    add(0, 0, 0,      0, 0, 0,      0, 0,  0,  0, 7,   0, 0, 1, 0, 7, 0,  32'h80);      // 23 still pending
    add(0, 0, 0,      1, 7, 64'h78, 0, 0,  0,  0, 7,   0, 1, 1, 0, 7, 0,  32'h80);      // 24
    add(0, 0, 0,      0, 0, 0,      0, 0,  0,  0, 7,   0, 0, 1, 1, 7, 64'h78, 32'h80);  // 25
    add(0, 0, 0,      0, 0, 0,      0, 0,  0,  0, 7,   0, 0, 0, 0, 7, 0,  32'h0);       // 26
    // WAW / RAW on x9; s0 write to x9 leaves it pending
    add(0, 0, 0,      0, 0, 0,      1, 9,  0,  0, 0,   0, 0, 0, 0, 7, 0,  32'h0);       // 27
    add(0, 0, 0,      0, 0, 0,      0, 0,  0,  0, 9,   0, 0, 1, 0, 7, 0,  32'h200);     // 28 WAW
    add(0, 0, 0,      0, 0, 0,      0, 0,  0,  9, 0,   0, 0, 1, 0, 7, 0,  32'h200);     // 29 RAW rs2
    add(0, 0, 0,      0, 0, 0,      0, 0,  10, 0, 0,   0, 0, 0, 0, 7, 0,  32'h200);     // 30 no hazard
    add(1, 9, 64'h99, 0, 0, 0,      0, 0,  9,  0, 0,   1, 0, 1, 0, 7, 0,  32'h200);     // 31
    add(0, 0, 0,      0, 0, 0,      0, 0,  9,  0, 0,   0, 0, 1, 1, 9, 64'h99, 32'h200); // 32
    add(0, 0, 0,      0, 0, 0,      0, 0,  9,  0, 0,   0, 0, 1, 0, 9, 0,  32'h200);     // 33

    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wr_en",   -1, 64'(bus.wr_en_o), 64'h0);
    chk("reset_wr_reg",  -1, 64'(bus.wr_reg_o), 64'h0);
    chk("reset_wr_data", -1, bus.wr_data_o, 64'h0);
    chk("reset_pend",    -1, 64'(bus.pend_mask_o), 64'h0);
    chk("reset_stall",   -1, 64'(bus.stall_o), 64'h0);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #3;
      chk("s0_ready", i, 64'(bus.s0_ready_o), 64'(vecs[i].e_s0rdy));
      chk("s1_ready", i, 64'(bus.s1_ready_o), 64'(vecs[i].e_s1rdy));
      chk("stall",    i, 64'(bus.stall_o),    64'(vecs[i].e_stall));
      chk("wr_en",    i, 64'(bus.wr_en_o),    64'(vecs[i].e_wen));
      chk("wr_reg",   i, 64'(bus.wr_reg_o),   64'(vecs[i].e_wreg));
      chk("pend",     i, 64'(bus.pend_mask_o), 64'(vecs[i].e_pend));
      if (vecs[i].e_wen) chk("wr_data", i, bus.wr_data_o, vecs[i].e_wd);
      @(posedge clk);
      #1;
    end

    // Async reset in the middle of a registered write, with x9 pending.
    idle_inputs();
    bus.s0_valid_i = 1'b1;
    bus.s0_reg_i   = 5'd3;
    bus.s0_data_i  = 64'h33;
    #3;
    @(posedge clk);
    #1;
    idle_inputs();
    chk("pre_rst_wr_en", 100, 64'(bus.wr_en_o), 64'h1);
    chk("pre_rst_pend",  100, 64'(bus.pend_mask_o), 64'h200);
    #1;
    rstn = 1'b0;
    #1;
    chk("mid_rst_wr_en",   101, 64'(bus.wr_en_o), 64'h0);
    chk("mid_rst_wr_reg",  101, 64'(bus.wr_reg_o), 64'h0);
    chk("mid_rst_wr_data", 101, bus.wr_data_o, 64'h0);
    chk("mid_rst_pend",    101, 64'(bus.pend_mask_o), 64'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    bus.chk_rs1_i = 5'd9;
    #3;
    chk("post_rst_pend",  102, 64'(bus.pend_mask_o), 64'h0);
    chk("post_rst_stall", 102, 64'(bus.stall_o), 64'h0);
    // counter restarts at 0: s0 wins the first contended cycle
    bus.s0_valid_i = 1'b1; bus.s0_reg_i = 5'd1;
    bus.s1_valid_i = 1'b1; bus.s1_reg_i = 5'd2;
    #1;
    chk("post_rst_s0_ready", 103, 64'(bus.s0_ready_o), 64'h1);
    chk("post_rst_s1_ready", 103, 64'(bus.s1_ready_o), 64'h0);
    @(posedge clk);
    #1;
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
